// File: rtl/vend_pkg.sv
// vend_pkg: state encoding and coin codes shared by the vending controller
// and its bench.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        VEND    = 2'b10,
        CHANGE  = 2'b11
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN1     = 2'b01;
    localparam logic [1:0] COIN2     = 2'b10;
    localparam logic [1:0] COIN3     = 2'b11;

endpackage

// File: rtl/vend_timeout.sv
// vend_timeout: inactivity counter for the COLLECT state. The count restarts
// whenever clear is high. While enabled, expire rises in the cycle where the
// count has reached TIMEOUT_CYC-1. That cycle is TIMEOUT_CYC edges after the
// last clear.
module vend_timeout
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    assign expire = enable && !clear && (count == LAST);

    // Count idle cycles. The count holds at LAST because the FSM leaves
    // COLLECT on expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: registered vending-machine controller. It owns the state, the
// credit accumulator and the registered vend/change/reject pulses.
// Optional feature macro VEND_CHANGE_EN:
//   - defined: a nonzero remainder after a vend is paid out as change.
//   - undefined: the remainder stays as credit in COLLECT.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int CREDIT_W    = 8,
    parameter int PRICE       = 15,
    parameter int COIN1_VAL   = 5,
    parameter int COIN2_VAL   = 10,
    parameter int COIN3_VAL   = 25,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          cn,
    input  logic                st,
    input  logic                can,
    output logic                vend,
    output logic                chg,
    output logic                rej,
    output logic [CREDIT_W-1:0] credit,
    output logic [1:0]          state
);

    localparam int SUM_W = CREDIT_W + 1;
    localparam logic [SUM_W-1:0]    CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [SUM_W-1:0]    VAL1       = SUM_W'(COIN1_VAL);
    localparam logic [SUM_W-1:0]    VAL2       = SUM_W'(COIN2_VAL);
    localparam logic [SUM_W-1:0]    VAL3       = SUM_W'(COIN3_VAL);
    localparam logic [SUM_W-1:0]    PRICE_W    = SUM_W'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_C     = CREDIT_W'(COIN1_VAL);

    // A bad parameter set cannot make change in whole units, so it stops
    // elaboration.
    if (COIN1_VAL <= 0) begin : g_bad_unit
        $fatal(1, "vend_ctrl: COIN1_VAL must be positive");
    end
    if (PRICE <= 0 || TIMEOUT_CYC < 1) begin : g_bad_range
        $fatal(1, "vend_ctrl: PRICE must be >0 and TIMEOUT_CYC >=1");
    end
    if ((PRICE % COIN1_VAL) != 0 || (COIN2_VAL % COIN1_VAL) != 0 ||
        (COIN3_VAL % COIN1_VAL) != 0) begin : g_bad_multiple
        $fatal(1, "vend_ctrl: PRICE, COIN2_VAL, COIN3_VAL must be multiples of COIN1_VAL");
    end

    state_t                state_q;
    logic [SUM_W-1:0]      coin_val;
    logic [SUM_W-1:0]      coin_sum;
    logic [CREDIT_W-1:0]   remainder;
    logic                  coin_in;
    logic                  coin_fits;
    logic                  can_buy;
    logic                  to_clear;
    logic                  to_enable;
    logic                  to_expire;

    assign state = state_q;

    // Decode the coin code into its credit value.
    always_comb begin
        coin_val = '0;
        case (cn)
            COIN1:   coin_val = VAL1;
            COIN2:   coin_val = VAL2;
            COIN3:   coin_val = VAL3;
            default: coin_val = '0;
        endcase
    end

    // The sum carries one extra bit so that an overflowing coin is detected
    // rather than wrapped.
    assign coin_in   = (cn != COIN_NONE);
    assign coin_sum  = {1'b0, credit} + coin_val;
    assign coin_fits = (coin_sum <= CREDIT_MAX);
    assign can_buy   = ({1'b0, credit} >= PRICE_W);
    assign remainder = credit - PRICE_C;

    // The idle count runs only in COLLECT. Any coin, accepted or rejected,
    // restarts the count.
    assign to_clear  = (state_q != COLLECT) || coin_in;
    assign to_enable = (state_q == COLLECT);

    vend_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (to_clear),
        .enable (to_enable),
        .expire (to_expire)
    );

    // One block holds the FSM, the credit datapath and the registered pulses.
    // vend and chg are set together with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            credit  <= '0;
            vend    <= 1'b0;
            chg     <= 1'b0;
            rej     <= 1'b0;
        end else begin
            vend <= 1'b0;
            chg  <= 1'b0;
            rej  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (coin_in) begin
                        if (coin_fits) begin
                            credit  <= coin_sum[CREDIT_W-1:0];
                            state_q <= COLLECT;
                        end else begin
                            rej <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (can) begin
                        state_q <= CHANGE;
                        chg     <= 1'b1;
                        rej     <= coin_in;
                    end else if (st && can_buy) begin
                        state_q <= VEND;
                        vend    <= 1'b1;
                        rej     <= coin_in;
                    end else if (coin_in) begin
                        if (coin_fits) begin
                            credit <= coin_sum[CREDIT_W-1:0];
                        end else begin
                            rej <= 1'b1;
                        end
                    end else if (to_expire) begin
                        state_q <= CHANGE;
                        chg     <= 1'b1;
                    end
                end
                VEND: begin
                    rej    <= coin_in;
                    credit <= remainder;
                    if (remainder == '0) begin
                        state_q <= IDLE;
                    end else begin
`ifdef VEND_CHANGE_EN
                        state_q <= CHANGE;
                        chg     <= 1'b1;
`else
                        state_q <= COLLECT;
`endif
                    end
                end
                CHANGE: begin
                    rej <= coin_in;
                    if (credit <= UNIT_C) begin
                        credit  <= '0;
                        state_q <= IDLE;
                    end else begin
                        credit <= credit - UNIT_C;
                        chg    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    credit  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: table-driven vectors, hand-written corner sequences and a
// randomized run against a behavioural model of the vending controller.
module tb_vend_ctrl;

    localparam int CREDIT_W = 5;
    localparam int PRICE    = 15;
    localparam int C1       = 5;
    localparam int C2       = 10;
    localparam int C3       = 25;
    localparam int TOUT     = 8;
    localparam int CMAX     = 31;

    typedef struct {
        int cn;
        int st;
        int can;
        int vend;
        int chg;
        int rej;
        int credit;
        int state;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [1:0]          cn;
    logic                st;
    logic                can;
    logic                vend;
    logic                chg;
    logic                rej;
    logic [CREDIT_W-1:0] credit;
    logic [1:0]          state;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[18];

    // Behavioural model: credit, pending units of change and plain flags.
    int mCredit;
    int mChangeLeft;
    int mIdle;
    int mCollect;
    int mVend;
    int mRej;

    always #5 clk = ~clk;

    vend_ctrl #(
        .CREDIT_W   (CREDIT_W),
        .PRICE      (PRICE),
        .COIN1_VAL  (C1),
        .COIN2_VAL  (C2),
        .COIN3_VAL  (C3),
        .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cn     (cn),
        .st     (st),
        .can    (can),
        .vend   (vend),
        .chg    (chg),
        .rej    (rej),
        .credit (credit),
        .state  (state)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkAll(input string name, input int v, input int c, input int r,
                            input int cr, input int s);
        checkOutput({name, ".vend"},   int'(vend),   v);
        checkOutput({name, ".chg"},    int'(chg),    c);
        checkOutput({name, ".rej"},    int'(rej),    r);
        checkOutput({name, ".credit"}, int'(credit), cr);
        checkOutput({name, ".state"},  int'(state),  s);
    endtask

    task automatic applyStimulus(input int c, input int s, input int a);
        @(negedge clk);
        cn  = 2'(c);
        st  = (s != 0);
        can = (a != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        mCredit     = 0;
        mChangeLeft = 0;
        mIdle       = 0;
        mCollect    = 0;
        mVend       = 0;
        mRej        = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        cn    = 2'b00;
        st    = 1'b0;
        can   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    // One clock of the vending rules for the given inputs.
    task automatic modelStep(input int c, input int s, input int a);
        int v;
        int coinIn;
        v      = (c == 1) ? C1 : (c == 2) ? C2 : (c == 3) ? C3 : 0;
        coinIn = (c != 0) ? 1 : 0;
        mRej   = 0;
        if (mVend != 0) begin
            mRej    = coinIn;
            mVend   = 0;
            mCredit = mCredit - PRICE;
            if (mCredit != 0) begin
`ifdef VEND_CHANGE_EN
                mChangeLeft = mCredit / C1;
`else
                mCollect = 1;
                mIdle    = 0;
`endif
            end
        end else if (mChangeLeft > 0) begin
            mRej        = coinIn;
            mChangeLeft = mChangeLeft - 1;
            mCredit     = mCredit - C1;
        end else if (mCollect != 0) begin
            if (a != 0) begin
                mRej        = coinIn;
                mChangeLeft = mCredit / C1;
                mCollect    = 0;
            end else if (s != 0 && mCredit >= PRICE) begin
                mRej     = coinIn;
                mVend    = 1;
                mCollect = 0;
            end else if (coinIn != 0) begin
                mIdle = 0;
                if (mCredit + v <= CMAX) mCredit = mCredit + v;
                else mRej = 1;
            end else begin
                mIdle = mIdle + 1;
                if (mIdle == TOUT) begin
                    mChangeLeft = mCredit / C1;
                    mCollect    = 0;
                end
            end
        end else if (coinIn != 0) begin
            if (v <= CMAX) begin
                mCredit  = v;
                mCollect = 1;
                mIdle    = 0;
            end else begin
                mRej = 1;
            end
        end
    endtask

    function automatic int modelState();
        if (mVend != 0) return 2;
        if (mChangeLeft > 0) return 3;
        if (mCollect != 0) return 1;
        return 0;
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hit;

        // cn, st, can | vend, chg, rej, credit, state
        vecs[0]  = '{1, 0, 0, 0, 0, 0,  5, 1};
        vecs[1]  = '{2, 0, 0, 0, 0, 0, 15, 1};
        vecs[2]  = '{1, 1, 0, 1, 0, 1, 15, 2};
        vecs[3]  = '{0, 0, 0, 0, 0, 0,  0, 0};
        vecs[4]  = '{0, 1, 1, 0, 0, 0,  0, 0};
        vecs[5]  = '{3, 0, 0, 0, 0, 0, 25, 1};
        vecs[6]  = '{2, 0, 0, 0, 0, 1, 25, 1};
        vecs[7]  = '{2, 0, 0, 0, 0, 1, 25, 1};
        vecs[8]  = '{1, 0, 1, 0, 1, 1, 25, 3};
        vecs[9]  = '{1, 0, 0, 0, 1, 1, 20, 3};
        vecs[10] = '{0, 0, 0, 0, 1, 0, 15, 3};
        vecs[11] = '{0, 0, 0, 0, 1, 0, 10, 3};
        vecs[12] = '{0, 0, 0, 0, 1, 0,  5, 3};
        vecs[13] = '{0, 0, 0, 0, 0, 0,  0, 0};
        vecs[14] = '{2, 0, 0, 0, 0, 0, 10, 1};
        vecs[15] = '{1, 0, 1, 0, 1, 1, 10, 3};
        vecs[16] = '{0, 0, 0, 0, 1, 0,  5, 3};
        vecs[17] = '{0, 0, 0, 0, 0, 0,  0, 0};

        rst_n = 1'b0;
        cn    = 2'b00;
        st    = 1'b0;
        can   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].cn, vecs[i].st, vecs[i].can);
            checkAll($sformatf("row%0d", i), vecs[i].vend, vecs[i].chg, vecs[i].rej,
                     vecs[i].credit, vecs[i].state);
        end

        // Coin 25 then ST: the remainder of 10 is either paid out or kept.
        doReset();
        applyStimulus(3, 0, 0);
        checkAll("buy25.coin", 0, 0, 0, 25, 1);
        applyStimulus(0, 1, 0);
        checkAll("buy25.vend", 1, 0, 0, 25, 2);
`ifdef VEND_CHANGE_EN
        applyStimulus(0, 0, 0);
        checkAll("buy25.chg1", 0, 1, 0, 10, 3);
        applyStimulus(0, 0, 0);
        checkAll("buy25.chg2", 0, 1, 0, 5, 3);
        applyStimulus(0, 0, 0);
        checkAll("buy25.idle", 0, 0, 0, 0, 0);
`else
        applyStimulus(0, 0, 0);
        checkAll("buy25.keep", 0, 0, 0, 10, 1);
        applyStimulus(0, 0, 0);
        checkAll("buy25.hold", 0, 0, 0, 10, 1);
        applyStimulus(0, 0, 1);
        checkAll("buy25.cancel", 0, 1, 0, 10, 3);
        applyStimulus(0, 0, 0);
        checkAll("buy25.chg", 0, 1, 0, 5, 3);
        applyStimulus(0, 0, 0);
        checkAll("buy25.idle", 0, 0, 0, 0, 0);
`endif

        // Timeout: CHANGE appears exactly TOUT edges after the coin edge.
        doReset();
        applyStimulus(1, 0, 0);
        hit = 0;
        for (int n = 1; n <= 20; n++) begin
            applyStimulus(0, 0, 0);
            if (state == 2'b11) begin
                hit = n;
                break;
            end
        end
        checkOutput("timeout.cycles", hit, TOUT);
        checkAll("timeout.chg", 0, 1, 0, 5, 3);
        applyStimulus(0, 0, 0);
        checkAll("timeout.idle", 0, 0, 0, 0, 0);

        // A coin in idle cycle 7 restarts the count.
        applyStimulus(1, 0, 0);
        for (int n = 1; n <= 6; n++) begin
            applyStimulus(0, 0, 0);
            checkOutput($sformatf("restart.wait%0d", n), int'(state), 1);
        end
        applyStimulus(1, 0, 0);
        checkAll("restart.coin", 0, 0, 0, 10, 1);
        hit = 0;
        for (int n = 1; n <= 20; n++) begin
            applyStimulus(0, 0, 0);
            if (state == 2'b11) begin
                hit = n;
                break;
            end
        end
        checkOutput("restart.cycles", hit, TOUT);
        checkAll("restart.chg1", 0, 1, 0, 10, 3);
        applyStimulus(0, 0, 0);
        checkAll("restart.chg2", 0, 1, 0, 5, 3);
        applyStimulus(0, 0, 0);
        checkAll("restart.idle", 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a refund.
        doReset();
        applyStimulus(3, 0, 0);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 0);
        checkAll("midchg.before", 0, 1, 0, 20, 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("midchg.reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();

        // Randomized run against the model. The coin density alternates so
        // that both overflow and timeout paths are reached.
        for (int i = 0; i < 4000; i++) begin
            int c;
            int s;
            int a;
            int coinPct;
            coinPct = (((i / 400) % 2) == 0) ? 40 : 8;
            c = ($urandom_range(99) < coinPct) ? int'($urandom_range(3, 1)) : 0;
            s = ($urandom_range(99) < 15) ? 1 : 0;
            a = ($urandom_range(99) < 4) ? 1 : 0;
            modelStep(c, s, a);
            applyStimulus(c, s, a);
            checkAll($sformatf("rand%0d", i), mVend, (mChangeLeft > 0) ? 1 : 0, mRej,
                     mCredit, modelState());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
